// File: rtl/rx_packet_parser.sv
// Purpose : byte framer behind the UART receiver. It finds SYNC_BYTE, then collects CMD, LEN, payload and XOR CHK, and streams the payload out.
// Latency : o_Data_Valid rises one clock after the CHK byte strobe. After that it delivers one byte per clock while i_Data_Ready is high.
// Backpr. : a low i_Data_Ready holds o_Data/o_Data_Last/o_Cmd/o_Len. Bytes that arrive during delivery are dropped and reported with o_Err_Overrun.
//
// Ports:
//   i_Clock, i_Reset_n (async, active-low)
//   i_RX_DV, i_RX_Byte           : byte strobe and data from the UART receiver
//   o_Data_Valid, i_Data_Ready,
//   o_Data, o_Data_Last          : payload stream (valid/ready)
//   o_Cmd, o_Len                 : header of the frame being delivered, 0 otherwise
//   o_Err_Chk/Len/Timeout/Overrun: single-cycle error pulses
//   o_Good_Cnt, o_Err_Cnt        : saturating statistics when RX_PARSER_STATS_EN is defined, else 0
module rx_packet_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 208320
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_Data_Valid,
  input  logic        i_Data_Ready,
  output logic [7:0]  o_Data,
  output logic        o_Data_Last,
  output logic [7:0]  o_Cmd,
  output logic [7:0]  o_Len,
  output logic        o_Err_Chk,
  output logic        o_Err_Len,
  output logic        o_Err_Timeout,
  output logic        o_Err_Overrun,
  output logic [15:0] o_Good_Cnt,
  output logic [15:0] o_Err_Cnt
);

  localparam int              IDX_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    GET_LEN,
    GET_PAYLOAD,
    GET_CHK,
    DELIVER
  } state_t;

  state_t          state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]      chk_q;
  logic [7:0]      cmd_q;
  logic [7:0]      len_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [7:0]      pay_mem [MAX_LEN];

  logic deliver;
  logic in_frame;
  logic at_last;
  logic xfer;
  logic len_bad;
  logic chk_bad;
  logic chk_ok;
  logic to_fire;
  logic overrun;

  assign deliver  = (state_q == DELIVER);
  assign in_frame = (state_q == GET_CMD) || (state_q == GET_LEN) ||
                    (state_q == GET_PAYLOAD) || (state_q == GET_CHK);
  // The same "index is LEN-1" compare serves both collection and delivery.
  assign at_last  = (8'(idx_q) == (len_q - 8'd1));
  assign xfer     = deliver && i_Data_Ready;

  // Next-state logic and the per-cycle event flags.
  always_comb begin
    state_d = state_q;
    len_bad = 1'b0;
    chk_bad = 1'b0;
    chk_ok  = 1'b0;
    to_fire = 1'b0;
    overrun = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) state_d = GET_CMD;
      end
      GET_CMD: begin
        if (i_RX_DV) state_d = GET_LEN;
      end
      GET_LEN: begin
        if (i_RX_DV) begin
          if ((i_RX_Byte == 8'd0) || (i_RX_Byte > MAX_LEN_B)) begin
            len_bad = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = GET_PAYLOAD;
          end
        end
      end
      GET_PAYLOAD: begin
        if (i_RX_DV && at_last) state_d = GET_CHK;
      end
      GET_CHK: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == chk_q) begin
            chk_ok  = 1'b1;
            state_d = DELIVER;
          end else begin
            chk_bad = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DELIVER: begin
        overrun = i_RX_DV;
        if (xfer && at_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // If a byte arrives on the limit cycle, the byte wins, because to_fire requires !i_RX_DV.
    if (in_frame && !i_RX_DV && (to_cnt_q == TO_LIMIT)) begin
      to_fire = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Header, checksum, index, timeout counter and error pulses.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      idx_q         <= '0;
      chk_q         <= 8'h00;
      cmd_q         <= 8'h00;
      len_q         <= 8'h00;
      to_cnt_q      <= '0;
      o_Err_Chk     <= 1'b0;
      o_Err_Len     <= 1'b0;
      o_Err_Timeout <= 1'b0;
      o_Err_Overrun <= 1'b0;
    end else begin
      o_Err_Chk     <= chk_bad;
      o_Err_Len     <= len_bad;
      o_Err_Timeout <= to_fire;
      o_Err_Overrun <= overrun;

      if (!in_frame || i_RX_DV) to_cnt_q <= '0;
      else if (!to_fire)        to_cnt_q <= to_cnt_q + TO_W'(1);

      if (i_RX_DV && !to_fire) begin
        case (state_q)
          GET_CMD: begin
            cmd_q <= i_RX_Byte;
            chk_q <= i_RX_Byte;
          end
          GET_LEN: begin
            if (!len_bad) begin
              len_q <= i_RX_Byte;
              chk_q <= chk_q ^ i_RX_Byte;
              idx_q <= '0;
            end
          end
          GET_PAYLOAD: begin
            chk_q <= chk_q ^ i_RX_Byte;
            idx_q <= idx_q + IDX_W'(1);
          end
          GET_CHK: begin
            if (chk_ok) idx_q <= '0;
          end
          default: ;
        endcase
      end

      if (xfer) idx_q <= idx_q + IDX_W'(1);
    end
  end

  // The payload store is not reset. Stale bytes are never presented, because the output is gated by deliver.
  always_ff @(posedge i_Clock) begin
    if ((state_q == GET_PAYLOAD) && i_RX_DV) pay_mem[idx_q] <= i_RX_Byte;
  end

  assign o_Data_Valid = deliver;
  assign o_Data       = deliver ? pay_mem[idx_q] : 8'h00;
  assign o_Data_Last  = deliver && at_last;
  assign o_Cmd        = deliver ? cmd_q : 8'h00;
  assign o_Len        = deliver ? len_q : 8'h00;

`ifdef RX_PARSER_STATS_EN
  logic [15:0] good_cnt_q;
  logic [15:0] err_cnt_q;
  logic        err_any;

  assign err_any = len_bad || chk_bad || to_fire || overrun;

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      good_cnt_q <= 16'h0000;
      err_cnt_q  <= 16'h0000;
    end else begin
      if (chk_ok && (good_cnt_q != 16'hFFFF)) good_cnt_q <= good_cnt_q + 16'd1;
      if (err_any && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign o_Good_Cnt = good_cnt_q;
  assign o_Err_Cnt  = err_cnt_q;
`else
  assign o_Good_Cnt = 16'h0000;
  assign o_Err_Cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_rx_packet_parser.sv
module tb_rx_packet_parser;

  localparam int T    = 20;
  localparam int MAXL = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [7:0]  rxb = 8'h00;
  logic        rdy = 1'b0;
  logic        o_vld, o_last, e_chk, e_len, e_to, e_ov;
  logic [7:0]  o_dat, o_cmd, o_len;
  logic [15:0] good_cnt, err_cnt;

  always #5 clk = ~clk;

  rx_packet_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CLKS(T)) dut (
    .i_Clock(clk), .i_Reset_n(rst_n), .i_RX_DV(dv), .i_RX_Byte(rxb),
    .o_Data_Valid(o_vld), .i_Data_Ready(rdy), .o_Data(o_dat), .o_Data_Last(o_last),
    .o_Cmd(o_cmd), .o_Len(o_len), .o_Err_Chk(e_chk), .o_Err_Len(e_len),
    .o_Err_Timeout(e_to), .o_Err_Overrun(e_ov), .o_Good_Cnt(good_cnt), .o_Err_Cnt(err_cnt)
  );

  int errors = 0;
  int checks = 0;
  int exp_good = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: counts error-pulse cycles, records transfers and flags any output change while stalled.
  int          cyc = 0;
  int          n_chk = 0, n_len = 0, n_to = 0, n_ov = 0, stall_bad = 0;
  logic [7:0]  rec_d [$];
  logic        rec_l [$];
  logic [7:0]  rec_c [$];
  logic [7:0]  rec_n [$];
  int          rec_cyc [$];
  logic        held_vld = 1'b0;
  logic [24:0] held = '0;

  always @(negedge clk) begin
    cyc++;
    n_chk += int'(e_chk);
    n_len += int'(e_len);
    n_to  += int'(e_to);
    n_ov  += int'(e_ov);
    if (held_vld && rst_n && (!o_vld || {o_dat, o_last, o_cmd, o_len} != held)) stall_bad++;
    held_vld = o_vld && !rdy && rst_n;
    held     = {o_dat, o_last, o_cmd, o_len};
    if (o_vld && rdy) begin
      rec_d.push_back(o_dat);
      rec_l.push_back(o_last);
      rec_c.push_back(o_cmd);
      rec_n.push_back(o_len);
      rec_cyc.push_back(cyc);
    end
  end

  task automatic clear_rx();
    rec_d.delete(); rec_l.delete(); rec_c.delete(); rec_n.delete(); rec_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    dv = 1'b1; rxb = b;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  // Payload is given LSB-first: byte i is at pay[8*i +: 8].
  task automatic check_rx(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                          input logic [127:0] pay, input bit consecutive);
    check({tag, "_count"}, 64'(rec_d.size()), 64'(len));
    for (int i = 0; i < rec_d.size() && i < int'(len); i++) begin
      check({tag, "_data"}, 64'(rec_d[i]), 64'(pay[8*i +: 8]));
      check({tag, "_last"}, 64'(rec_l[i]), 64'(i == int'(len) - 1));
      check({tag, "_cmd"},  64'(rec_c[i]), 64'(cmd));
      check({tag, "_len"},  64'(rec_n[i]), 64'(len));
      if (consecutive) check({tag, "_b2b"}, 64'(rec_cyc[i] - rec_cyc[0]), 64'(i));
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef RX_PARSER_STATS_EN
    check({tag, "_good_cnt"}, 64'(good_cnt), 64'(exp_good));
    check({tag, "_err_cnt"},  64'(err_cnt),  64'(exp_err));
`else
    check({tag, "_good_cnt"}, 64'(good_cnt), 64'd0);
    check({tag, "_err_cnt"},  64'(err_cnt),  64'd0);
`endif
  endtask

  function automatic logic [63:0] all_outs();
    return {o_vld, o_dat, o_last, o_cmd, o_len, e_chk, e_len, e_to, e_ov, good_cnt, err_cnt};
  endfunction

  // Stream bytes are written MSB-first, so byte i is at bytes[8*(n-1-i) +: 8]; pay uses the same order with len.
  typedef struct packed {
    logic [7:0]  n;
    logic [95:0] bytes;
    logic [1:0]  kind;   // 0 good, 1 checksum error, 2 length error
    logic [7:0]  cmd;
    logic [7:0]  len;
    logic [31:0] pay;
  } vec_t;

  vec_t vecs [7];

  task automatic apply_vec(input int k);
    vec_t v;
    logic [127:0] pl;
    int b_chk, b_len, b_to, b_ov;
    string tag;
    v = vecs[k];
    tag = $sformatf("vec%0d", k);
    b_chk = n_chk; b_len = n_len; b_to = n_to; b_ov = n_ov;
    clear_rx();
    rdy = 1'b1;
    for (int i = 0; i < int'(v.n); i++) send_byte(v.bytes[8*(int'(v.n)-1-i) +: 8]);
    @(negedge clk);
    check({tag, "_vld_latency"}, 64'(o_vld), 64'(v.kind == 2'd0));
    repeat (MAXL + 4) @(negedge clk);
    pl = '0;
    for (int i = 0; i < int'(v.len); i++) pl[8*i +: 8] = v.pay[8*(int'(v.len)-1-i) +: 8];
    if (v.kind == 2'd0) begin
      check_rx(tag, v.cmd, v.len, pl, 1'b1);
      exp_good++;
    end else begin
      check({tag, "_no_delivery"}, 64'(rec_d.size()), 64'd0);
      exp_err++;
    end
    check({tag, "_err_chk"}, 64'(n_chk - b_chk), 64'(v.kind == 2'd1));
    check({tag, "_err_len"}, 64'(n_len - b_len), 64'(v.kind == 2'd2));
    check({tag, "_err_to_ov"}, 64'((n_to - b_to) + (n_ov - b_ov)), 64'd0);
    check({tag, "_idle_after"}, 64'(o_vld), 64'd0);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_chk, b_len, b_to, b_ov, b_stall;
    logic [127:0] pl;

    vecs[0] = '{8'd9, 96'h00_FF_A5_10_03_11_22_33_13, 2'd0, 8'h10, 8'd3, 32'h112233};
    vecs[1] = '{8'd7, 96'hA5_10_03_11_22_33_14,       2'd1, 8'h00, 8'd0, 32'h0};
    vecs[2] = '{8'd7, 96'hA5_10_03_11_22_33_13,       2'd0, 8'h10, 8'd3, 32'h112233};
    vecs[3] = '{8'd3, 96'hA5_07_00,                   2'd2, 8'h00, 8'd0, 32'h0};
    vecs[4] = '{8'd3, 96'hA5_07_11,                   2'd2, 8'h00, 8'd0, 32'h0};
    vecs[5] = '{8'd9, 96'hA5_07_A5_10_03_11_22_33_13, 2'd2, 8'h00, 8'd0, 32'h0};
    vecs[6] = '{8'd5, 96'hA5_42_01_5A_19,             2'd0, 8'h42, 8'd1, 32'h5A};

    // Reset state
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", all_outs(), 64'd0);

    for (int k = 0; k < 7; k++) apply_vec(k);
    check_stats("after_table");

    // Maximum length: LEN=16, payload 00..0F (XOR 0), CHK = 01^10 = 11
    clear_rx();
    rdy = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h11);
    repeat (MAXL + 4) @(negedge clk);
    for (int i = 0; i < 16; i++) pl[8*i +: 8] = 8'(i);
    check_rx("maxlen", 8'h01, 8'd16, pl, 1'b1);
    exp_good++;

    // Backpressure of 5 cycles per byte, plus a byte that arrives during delivery
    clear_rx();
    b_ov = n_ov; b_stall = stall_bad;
    rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
    send_byte(8'h77);
    for (int k = 0; k < 3; k++) begin
      repeat (5) @(posedge clk);
      #1 rdy = 1'b1;
      @(posedge clk);
      #1 rdy = 1'b0;
    end
    repeat (4) @(negedge clk);
    check_rx("bp", 8'h10, 8'd3, 128'h33_22_11, 1'b0);
    check("bp_stall_stable", 64'(stall_bad - b_stall), 64'd0);
    check("bp_overrun", 64'(n_ov - b_ov), 64'd1);
    check("bp_idle_after", 64'(o_vld), 64'd0);
    exp_good++; exp_err++;

    // Timeout: the next byte arrives one clock after the limit, so the frame is aborted
    clear_rx();
    b_to = n_to;
    rdy = 1'b1;
    send_byte(8'hA5); send_byte(8'h10);
    repeat (T - 1) @(posedge clk);
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h4B);
    repeat (6) @(negedge clk);
    check("timeout_pulse", 64'(n_to - b_to), 64'd1);
    check("timeout_no_delivery", 64'(rec_d.size()), 64'd0);
    exp_err++;
    apply_vec(2);

    // A byte that arrives exactly at count T-1 wins over the timeout
    clear_rx();
    b_to = n_to;
    send_byte(8'hA5); send_byte(8'h10);
    repeat (T - 2) @(posedge clk);
    send_byte(8'h01); send_byte(8'h5A); send_byte(8'h4B);
    repeat (6) @(negedge clk);
    check("limit_no_timeout", 64'(n_to - b_to), 64'd0);
    check_rx("limit", 8'h10, 8'd1, 128'h5A, 1'b0);
    exp_good++;
    check_stats("before_reset");

    // Reset mid-payload: the frame is discarded and the tail bytes are ignored
    clear_rx();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h03); send_byte(8'h11);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check("rst_payload_outputs", all_outs(), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_good = 0; exp_err = 0;
    b_chk = n_chk; b_len = n_len; b_to = n_to; b_ov = n_ov;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h13);
    repeat (T + 4) @(negedge clk);
    check("rst_payload_no_delivery", 64'(rec_d.size()), 64'd0);
    check("rst_payload_no_err", 64'((n_chk - b_chk) + (n_len - b_len) + (n_to - b_to) + (n_ov - b_ov)), 64'd0);

    // Reset mid-delivery: the outputs drop at once
    rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h42); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h19);
    @(negedge clk);
    check("rst_deliver_vld_before", 64'(o_vld), 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rst_deliver_outputs", all_outs(), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_good = 0; exp_err = 0;
    apply_vec(0);
    check_stats("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
